display_scan_controller: RTL and testbench

- Sequences the four-digit multiplexed 7-segment display used for game output.
- Snapshots dealer total, player total and game-state code, then scans digits with a refresh divider.
- Selects the content by game phase: totals, dealer-hidden totals, or an alternating result message.
- Sits between the game FSM and the board's anode/segment pins, in place of static output wiring.

---
 rtl/disp_pkg.sv | 159 +++++++++++++++
 rtl/seg_refresh_timer.sv | 46 ++++
 rtl/display_scan_controller.sv | 184 ++++++++++++++++++
 tb/tb_display_scan_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the four-digit game display.
// Contents:
//   - Field widths for totals, state code, BCD digits, digit index and segments.
//   - disp_state_t: game phase code driven by the game FSM.
//   - disp_mode_t: what the scanner shows (idle dashes, totals, hidden dealer, result).
//   - glyph_t and SEG_* constants: active-low {g,f,e,d,c,b,a} patterns.
//   - to_bcd(), glyph(), digit_glyph(), tens_glyph() and mode_of().
// Build option: DISP_LEADING_ZERO_BLANK_EN blanks a zero tens digit inside tens_glyph().
package disp_pkg;

  localparam int unsigned TOTAL_W    = 5;
  localparam int unsigned STATE_W    = 3;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned GLYPH_W    = 5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE        = 3'd0,
    S_DEAL        = 3'd1,
    S_PLAYER_TURN = 3'd2,
    S_DEALER_TURN = 3'd3,
    S_PLAYER_WIN  = 3'd4,
    S_DEALER_WIN  = 3'd5,
    S_PUSH        = 3'd6
  } disp_state_t;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_TOTALS = 2'd1,
    M_HIDDEN = 2'd2,
    M_RESULT = 2'd3
  } disp_mode_t;

  // Digit glyphs share their numeric value so a BCD digit maps directly.
  typedef enum logic [GLYPH_W-1:0] {
    G_0     = 5'd0,
    G_1     = 5'd1,
    G_2     = 5'd2,
    G_3     = 5'd3,
    G_4     = 5'd4,
    G_5     = 5'd5,
    G_6     = 5'd6,
    G_7     = 5'd7,
    G_8     = 5'd8,
    G_9     = 5'd9,
    G_P     = 5'd10,
    G_D     = 5'd11,
    G_U     = 5'd12,
    G_S     = 5'd13,
    G_H     = 5'd14,
    G_DASH  = 5'd15,
    G_BLANK = 5'd16
  } glyph_t;

  // Snapshot of the game FSM outputs taken at a frame boundary.
  typedef struct packed {
    logic [TOTAL_W-1:0] dealer;
    logic [TOTAL_W-1:0] player;
    logic [STATE_W-1:0] state;
  } disp_snap_t;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_P     = 7'h0C;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_U     = 7'h41;
  localparam logic [SEG_W-1:0] SEG_S     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_H     = 7'h09;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Totals never exceed 31, so a compare ladder replaces a divider.
  function automatic bcd_t to_bcd(input logic [TOTAL_W-1:0] total);
    bcd_t               r;
    logic [TOTAL_W-1:0] base;
    if (total >= 5'd30) begin
      r.tens = 4'd3;
      base   = 5'd30;
    end else if (total >= 5'd20) begin
      r.tens = 4'd2;
      base   = 5'd20;
    end else if (total >= 5'd10) begin
      r.tens = 4'd1;
      base   = 5'd10;
    end else begin
      r.tens = 4'd0;
      base   = 5'd0;
    end
    r.ones = BCD_W'(total - base);
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] glyph(input glyph_t g);
    logic [SEG_W-1:0] s;
    case (g)
      G_0:     s = SEG_0;
      G_1:     s = SEG_1;
      G_2:     s = SEG_2;
      G_3:     s = SEG_3;
      G_4:     s = SEG_4;
      G_5:     s = SEG_5;
      G_6:     s = SEG_6;
      G_7:     s = SEG_7;
      G_8:     s = SEG_8;
      G_9:     s = SEG_9;
      G_P:     s = SEG_P;
      G_D:     s = SEG_D;
      G_U:     s = SEG_U;
      G_S:     s = SEG_S;
      G_H:     s = SEG_H;
      G_DASH:  s = SEG_DASH;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic glyph_t digit_glyph(input logic [BCD_W-1:0] d);
    return glyph_t'(GLYPH_W'(d));
  endfunction

  function automatic glyph_t tens_glyph(input logic [BCD_W-1:0] d);
    glyph_t g;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    g = (d == '0) ? G_BLANK : digit_glyph(d);
`else
    g = digit_glyph(d);
`endif
    return g;
  endfunction

  // Unlisted state codes fall back to the idle dashes.
  function automatic disp_mode_t mode_of(input logic [STATE_W-1:0] code);
    disp_mode_t m;
    case (code)
      S_DEAL, S_DEALER_TURN:            m = M_TOTALS;
      S_PLAYER_TURN:                    m = M_HIDDEN;
      S_PLAYER_WIN, S_DEALER_WIN, S_PUSH: m = M_RESULT;
      default:                          m = M_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Refresh divider and digit scan index for the multiplexed display.
// Ports:
//   clk_i, reset_i   clock and asynchronous active-high reset
//   tick_c_o         high on the last cycle of each digit slot
//   digit_o          current digit index; steps 3,2,1,0 on each tick
//   frame_end_c_o    tick while the index is 0 (the 0 -> 3 wrap)
// The index resets to 0, so the very first tick is a frame boundary and
// scanning begins at digit 3.
module seg_refresh_timer
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               tick_c_o,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               frame_end_c_o
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  // Divider wrap and index step.
  always_comb begin
    tick_c_o      = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    frame_end_c_o = tick_c_o && (digit_q == '0);
    cnt_d         = tick_c_o ? '0 : CNT_W'(cnt_q + 1'b1);
    digit_d       = tick_c_o ? DIGIT_W'(digit_q - 1'b1) : digit_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scanner for the game display.
// Snapshots dealer total, player total and game phase at frame boundaries
// (after a load request), picks the display mode from the snapshot and
// drives one digit per refresh slot.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dealer_total, player_total hand values 0..31
//   state_code                 game phase (disp_state_t encoding)
//   load / load_ack            snapshot request / one-cycle snapshot pulse
//   an_n                       digit enables, active low, bit3 = leftmost
//   seg_n                      segments {g,f,e,d,c,b,a}, active low
//   dp_n                       decimal point, active low (dealer/player separator)
// Build option: DISP_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module display_scan_controller
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned MSG_FRAMES  = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TOTAL_W-1:0]    dealer_total,
  input  logic [TOTAL_W-1:0]    player_total,
  input  logic [STATE_W-1:0]    state_code,
  input  logic                  load,
  output logic                  load_ack,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [SEG_W-1:0]      seg_n,
  output logic                  dp_n
);

  localparam int unsigned FRM_W = (MSG_FRAMES > 1) ? $clog2(MSG_FRAMES) : 1;

  logic               tick;
  logic               frame_end;
  logic [DIGIT_W-1:0] digit;
  logic [DIGIT_W-1:0] digit_nxt;
  logic               take;

  logic                  pending_q, pending_d;
  disp_snap_t            snap_q, snap_d;
  disp_mode_t            mode_q, mode_d;
  logic [FRM_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  show_totals_q, show_totals_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  ack_q, ack_d;

  bcd_t   dealer_bcd;
  bcd_t   player_bcd;
  bcd_t   tot_bcd;
  glyph_t tot_glyph;
  glyph_t msg_glyph;
  glyph_t sel_glyph;
  logic   sep;

  seg_refresh_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_timer (
    .clk_i        (clk),
    .reset_i      (reset),
    .tick_c_o     (tick),
    .digit_o      (digit),
    .frame_end_c_o(frame_end)
  );

  // Load handshake, mode selection and per-slot output decode.
  always_comb begin
    pending_d     = pending_q;
    snap_d        = snap_q;
    mode_d        = mode_q;
    frame_cnt_d   = frame_cnt_q;
    show_totals_d = show_totals_q;
    an_d          = an_q;
    seg_d         = seg_q;
    dp_d          = dp_q;

    digit_nxt = DIGIT_W'(digit - 1'b1);

    // A load on the boundary cycle itself joins that boundary's snapshot.
    take      = frame_end && (pending_q || load);
    ack_d     = take;
    pending_d = take ? 1'b0 : (pending_q || load);
    if (take) begin
      snap_d = '{dealer: dealer_total, player: player_total, state: state_code};
    end

    // Mode and result alternation only move at frame boundaries.
    if (frame_end) begin
      mode_d = mode_of(snap_d.state);
      if (mode_d == M_RESULT) begin
        if (mode_q != M_RESULT) begin
          frame_cnt_d   = '0;
          show_totals_d = 1'b0;
        end else if (frame_cnt_q == FRM_W'(MSG_FRAMES - 1)) begin
          frame_cnt_d   = '0;
          show_totals_d = !show_totals_q;
        end else begin
          frame_cnt_d = FRM_W'(frame_cnt_q + 1'b1);
        end
      end
    end

    // Digits 3:2 carry the dealer total, 1:0 the player total; odd index is tens.
    dealer_bcd = to_bcd(snap_d.dealer);
    player_bcd = to_bcd(snap_d.player);
    tot_bcd    = digit_nxt[1] ? dealer_bcd : player_bcd;
    tot_glyph  = digit_nxt[0] ? tens_glyph(tot_bcd.tens) : digit_glyph(tot_bcd.ones);

    msg_glyph = G_DASH;
    case (snap_d.state)
      S_PLAYER_WIN: msg_glyph = (digit_nxt == 2'd3) ? G_P : G_DASH;
      S_DEALER_WIN: msg_glyph = (digit_nxt == 2'd3) ? G_D : G_DASH;
      S_PUSH: begin
        case (digit_nxt)
          2'd3:    msg_glyph = G_P;
          2'd2:    msg_glyph = G_U;
          2'd1:    msg_glyph = G_S;
          default: msg_glyph = G_H;
        endcase
      end
      default: msg_glyph = G_DASH;
    endcase

    sel_glyph = G_DASH;
    sep       = 1'b0;
    case (mode_d)
      M_TOTALS: begin
        sel_glyph = tot_glyph;
        sep       = 1'b1;
      end
      M_HIDDEN: begin
        sel_glyph = digit_nxt[1] ? G_DASH : tot_glyph;
        sep       = 1'b1;
      end
      M_RESULT: begin
        sel_glyph = show_totals_d ? tot_glyph : msg_glyph;
        sep       = show_totals_d;
      end
      default: begin
        sel_glyph = G_DASH;
        sep       = 1'b0;
      end
    endcase

    // Outputs hold between ticks and show the incoming digit after each tick.
    if (tick) begin
      an_d  = ~(NUM_DIGITS'(1) << digit_nxt);
      seg_d = glyph(sel_glyph);
      dp_d  = !(sep && (digit_nxt == 2'd2));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q     <= 1'b0;
      snap_q        <= '0;
      mode_q        <= M_IDLE;
      frame_cnt_q   <= '0;
      show_totals_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      ack_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      snap_q        <= snap_d;
      mode_q        <= mode_d;
      frame_cnt_q   <= frame_cnt_d;
      show_totals_q <= show_totals_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      ack_q         <= ack_d;
    end
  end

  assign load_ack = ack_q;
  assign an_n     = an_q;
  assign seg_n    = seg_q;
  assign dp_n     = dp_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with REFRESH_DIV=4, MSG_FRAMES=2.
// A frame-level reference model pushes the four expected digit slots at each
// frame boundary; a monitor pops one entry whenever the anode pattern changes.
module tb_display_scan_controller;

  localparam int unsigned DIV       = 4;
  localparam int unsigned MF        = 2;
  localparam int          FRAME     = 16;
  localparam int          BOUND_OFS = 4;

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic [4:0] dealer_total = '0;
  logic [4:0] player_total = '0;
  logic [2:0] state_code   = '0;
  logic       load         = 1'b0;
  logic       load_ack;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  display_scan_controller #(
    .REFRESH_DIV(DIV),
    .MSG_FRAMES (MF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dealer_total(dealer_total),
    .player_total(player_total),
    .state_code  (state_code),
    .load        (load),
    .load_ack    (load_ack),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   acks_seen  = 0;
  int   p          = 0;

  // Model state: pending request, snapshot, mode (0 idle,1 totals,2 hidden,3 result),
  // frames spent in the current result episode.
  bit m_pend = 0;
  int m_d = 0, m_p = 0, m_s = 0, m_mode = 0, m_rf = 0;

  // Lit segments (active high) for each character the display can show.
  function automatic logic [6:0] seg_on(input byte c);
    case (c)
      "0": return 7'h3F;
      "1": return 7'h06;
      "2": return 7'h5B;
      "3": return 7'h4F;
      "4": return 7'h66;
      "5": return 7'h6D;
      "6": return 7'h7D;
      "7": return 7'h07;
      "8": return 7'h7F;
      "9": return 7'h6F;
      "P": return 7'h73;
      "d": return 7'h5E;
      "U": return 7'h3E;
      "S": return 7'h6D;
      "H": return 7'h76;
      "-": return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int category(input int s);
    case (s)
      1, 3:    return 1;
      2:       return 2;
      4, 5, 6: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic byte num_ch(input int v);
    return byte'(48 + v);
  endfunction

  function automatic byte tens_ch(input int v);
`ifdef DISP_LEADING_ZERO_BLANK_EN
    if (v / 10 == 0) return " ";
`endif
    return num_ch(v / 10);
  endfunction

  // Reference model: evaluates the display at each frame boundary.
  always @(posedge clk) begin : model
    byte  txt[4];
    int   prev_mode;
    int   digit;
    bit   took;
    bit   sep;
    exp_t e;
    if (reset) begin
      p      = 0;
      m_pend = 0;
      m_d    = 0;
      m_p    = 0;
      m_s    = 0;
      m_mode = 0;
      m_rf   = 0;
    end else begin
      p = p + 1;
      if (p % FRAME == BOUND_OFS) begin
        took = m_pend || load;
        if (took) begin
          m_d    = int'(dealer_total);
          m_p    = int'(player_total);
          m_s    = int'(state_code);
          m_pend = 0;
        end
        prev_mode = m_mode;
        m_mode    = category(m_s);
        if (m_mode == 3) m_rf = (prev_mode == 3) ? m_rf + 1 : 0;
        sep = (m_mode == 1) || (m_mode == 2) || (m_mode == 3 && ((m_rf / MF) % 2 == 1));
        txt[0] = "-"; txt[1] = "-"; txt[2] = "-"; txt[3] = "-";
        if (m_mode == 2) begin
          txt[2] = tens_ch(m_p);
          txt[3] = num_ch(m_p % 10);
        end else if (m_mode == 1 || (m_mode == 3 && sep)) begin
          txt[0] = tens_ch(m_d);
          txt[1] = num_ch(m_d % 10);
          txt[2] = tens_ch(m_p);
          txt[3] = num_ch(m_p % 10);
        end else if (m_mode == 3) begin
          if (m_s == 4) txt[0] = "P";
          else if (m_s == 5) txt[0] = "d";
          else begin
            txt[0] = "P"; txt[1] = "U"; txt[2] = "S"; txt[3] = "H";
          end
        end
        for (int i = 0; i < 4; i++) begin
          digit  = 3 - i;
          e.an   = 4'hF ^ (4'h1 << digit);
          e.seg  = ~seg_on(txt[i]);
          e.dp   = !(sep && digit == 2);
          e.ack  = (i == 0) && took;
          sb.push_back(e);
        end
      end else if (load) begin
        m_pend = 1;
      end
    end
  end

  logic [3:0] prev_an = 4'hF;

  // Monitor: each anode change is a new digit slot.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      prev_an = an_n;
    end else begin
      if (load_ack === 1'b1) acks_seen++;
      checks++;
      if (an_n != prev_an) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL slot_unexpected: an_n=%b seg_n=%h dp_n=%b changed with nothing expected",
                   an_n, seg_n, dp_n);
        end else begin
          e = sb.pop_front();
          if ({an_n, seg_n, dp_n, load_ack} !== {e.an, e.seg, e.dp, e.ack}) begin
            errors++;
            $display("FAIL slot t=%0t: got an=%b seg=%h dp=%b ack=%b, expected an=%b seg=%h dp=%b ack=%b",
                     $time, an_n, seg_n, dp_n, load_ack, e.an, e.seg, e.dp, e.ack);
          end
        end
      end else if (load_ack !== 1'b0) begin
        errors++;
        $display("FAIL ack_spurious t=%0t: load_ack=%b expected 0", $time, load_ack);
      end
      prev_an = an_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int d, input int pl, input int s);
    @(negedge clk);
    dealer_total = 5'(d);
    player_total = 5'(pl);
    state_code   = 3'(s);
    load         = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  // Bounded wait until the model's cycle position within a frame equals ofs.
  task automatic align_to(input int ofs);
    for (int k = 0; k < 2 * FRAME && (p % FRAME) != ofs; k++) @(negedge clk);
  endtask

  initial begin : main
    int a0;
    repeat (4) @(negedge clk);
    chk("reset_an", 32'(an_n), 32'hF);
    chk("reset_seg", 32'(seg_n), 32'h7F);
    chk("reset_dp", 32'(dp_n), 32'h1);
    chk("reset_ack", 32'(load_ack), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_tick_an", 32'(an_n), 32'hF);
    chk("pre_tick_seg", 32'(seg_n), 32'h7F);

    // Totals, hidden dealer, result alternation.
    apply(17, 20, 3);
    wait_frames(3);
    apply(9, 5, 2);
    wait_frames(2);
    apply(18, 18, 6);
    wait_frames(6);

    // Three loads inside one frame collapse into a single acknowledge.
    align_to(5);
    a0 = acks_seen;
    apply(10, 3, 3);
    repeat (2) @(negedge clk);
    apply(15, 3, 3);
    repeat (2) @(negedge clk);
    apply(21, 3, 3);
    align_to(6);
    chk("coalesce_acks", 32'(acks_seen - a0), 32'd1);
    wait_frames(1);

    // Load on the boundary cycle itself.
    align_to(3);
    a0 = acks_seen;
    dealer_total = 5'd25;
    player_total = 5'd30;
    state_code   = 3'd5;
    load         = 1'b1;
    @(negedge clk);
    load = 1'b0;
    align_to(6);
    chk("boundary_load_ack", 32'(acks_seen - a0), 32'd1);
    wait_frames(5);

    // Reset mid-digit while a result is up, with a load still pending.
    apply(21, 15, 4);
    wait_frames(2);
    apply(5, 5, 6);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_an", 32'(an_n), 32'hF);
    chk("midrst_seg", 32'(seg_n), 32'h7F);
    chk("midrst_dp", 32'(dp_n), 32'h1);
    chk("midrst_ack", 32'(load_ack), 32'h0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_frames(3);

    // Randomised traffic, including undefined state codes.
    for (int it = 0; it < 40; it++) begin
      int nloads;
      nloads = int'($urandom_range(1, 3));
      for (int l = 0; l < nloads; l++) begin
        apply(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)));
        repeat (int'($urandom_range(0, 9))) @(negedge clk);
      end
      repeat (int'($urandom_range(8, 40))) @(negedge clk);
    end

    wait_frames(2);
    chk("sb_drain", 32'(sb.size() <= 4), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
